// File: rtl/fifo_rd_serializer.sv
// Drains a show-ahead FIFO and emits each wide word as IN_W/OUT_W narrow
// valid/ready beats, least-significant slice first, with gapless reload.
module fifo_rd_serializer #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_empty,
  input  logic [IN_W-1:0]  i_rddata,
  output logic             o_rden,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [BW-1:0] ONE       = BW'(1);

  // state | meaning
  // EMPTY | no word held, waiting for the FIFO to present one
  // SEND  | word held, beats being offered downstream
  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] word_q, word_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic full;
  logic last_xfer;
  logic load;

  assign full      = (state_q == SEND);
  assign last_xfer = full && i_ready && (beat_q == LAST_BEAT);
  // rstn gates the pop so a FIFO word is not consumed while the stage is held in reset
  assign load      = rstn && !i_empty && !i_flush && (!full || last_xfer);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
    if (i_flush) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else if (load) begin
      state_d = SEND;
      word_d  = i_rddata;
      beat_d  = '0;
    end else if (last_xfer) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else if (full && i_ready) begin
      beat_d  = beat_q + ONE;
    end
  end

  always_comb begin
    o_rden  = load;
    o_valid = full;
    o_busy  = full;
    o_last  = full && (beat_q == LAST_BEAT);
    o_data  = word_q[int'(beat_q) * OUT_W +: OUT_W];
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer with a small show-ahead FIFO model
// feeding the read port.
module tb_fifo_rd_serializer;

  localparam int IN_W  = 128;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rstn;
  logic             i_empty;
  logic [IN_W-1:0]  i_rddata;
  logic             o_rden;
  logic             i_flush;
  logic             o_valid;
  logic [OUT_W-1:0] o_data;
  logic             i_ready;
  logic             o_last;
  logic             o_busy;

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0] mem [16];
  int rd = 0;
  int wr = 0;

  localparam logic [IN_W-1:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [IN_W-1:0] WA = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [IN_W-1:0] WB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [IN_W-1:0] WC = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

  assign i_empty  = (rd == wr);
  assign i_rddata = mem[rd % 16];

  always @(posedge clk) if (o_rden && !i_empty) rd <= rd + 1;

  fifo_rd_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rstn(rstn), .i_empty(i_empty), .i_rddata(i_rddata),
    .o_rden(o_rden), .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_last(o_last), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [IN_W-1:0] w);
    mem[wr % 16] = w;
    wr = wr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [OUT_W-1:0] d, input logic last, input logic rden);
    chk({tag, "_valid"}, IN_W'(o_valid), IN_W'(1'b1));
    chk({tag, "_data"},  IN_W'(o_data),  IN_W'(d));
    chk({tag, "_last"},  IN_W'(o_last),  IN_W'(last));
    chk({tag, "_rden"},  IN_W'(o_rden),  IN_W'(rden));
  endtask

  task automatic idle(input string tag);
    chk({tag, "_valid"}, IN_W'(o_valid), IN_W'(1'b0));
    chk({tag, "_busy"},  IN_W'(o_busy),  IN_W'(1'b0));
    chk({tag, "_last"},  IN_W'(o_last),  IN_W'(1'b0));
  endtask

  initial begin
    logic [IN_W-1:0] w3 [3];
    logic [IN_W-1:0] cur;
    w3[0] = WA; w3[1] = WB; w3[2] = WC;
    rstn = 1'b0; i_flush = 1'b0; i_ready = 1'b1;

    // Reset with a word already waiting: nothing may pop or be presented
    push(W1);
    #1;
    idle("rst");
    chk("rst_rden", IN_W'(o_rden), IN_W'(1'b0));
    chk("rst_data", IN_W'(o_data), '0);
    tick();
    rstn = 1'b1;
    #1;

    // 1: single word
    chk("t1_load_rden", IN_W'(o_rden), IN_W'(1'b1));
    chk("t1_load_valid", IN_W'(o_valid), IN_W'(1'b0));
    tick(); beat("t1_b0", 32'h11111111, 1'b0, 1'b0);
    chk("t1_busy", IN_W'(o_busy), IN_W'(1'b1));
    tick(); beat("t1_b1", 32'h22222222, 1'b0, 1'b0);
    tick(); beat("t1_b2", 32'h33333333, 1'b0, 1'b0);
    tick(); beat("t1_b3", 32'h44444444, 1'b1, 1'b0);
    tick(); idle("t1_after");

    // 2: backpressure during beat 1
    push(W1);
    #1;
    chk("t2_load_rden", IN_W'(o_rden), IN_W'(1'b1));
    tick(); beat("t2_b0", 32'h11111111, 1'b0, 1'b0);
    tick();
    i_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      beat("t2_stall", 32'h22222222, 1'b0, 1'b0);
      tick();
    end
    i_ready = 1'b1;
    #1;
    beat("t2_b1", 32'h22222222, 1'b0, 1'b0);
    tick(); beat("t2_b2", 32'h33333333, 1'b0, 1'b0);
    tick(); beat("t2_b3", 32'h44444444, 1'b1, 1'b0);
    tick(); idle("t2_after");

    // 3: three words back to back
    push(WA); push(WB); push(WC);
    #1;
    chk("t3_c0_rden", IN_W'(o_rden), IN_W'(1'b1));
    for (int c = 1; c <= 12; c++) begin
      tick();
      cur = w3[(c - 1) / 4];
      beat($sformatf("t3_c%0d", c), cur[((c - 1) % 4) * OUT_W +: OUT_W],
           (c % 4) == 0, (c == 4) || (c == 8));
    end
    tick(); idle("t3_after");

    // 4: empty FIFO for 20 cycles, then a push
    for (int c = 0; c < 20; c++) begin
      idle("t4_empty");
      chk("t4_empty_rden", IN_W'(o_rden), IN_W'(1'b0));
      tick();
    end
    push(W1);
    #1;
    chk("t4_c20_rden", IN_W'(o_rden), IN_W'(1'b1));
    chk("t4_c20_valid", IN_W'(o_valid), IN_W'(1'b0));
    tick(); beat("t4_c21", 32'h11111111, 1'b0, 1'b0);
    tick(); tick(); tick();
    beat("t4_b3", 32'h44444444, 1'b1, 1'b0);
    tick(); idle("t4_after");

    // 5: flush during beat 2 with next word waiting
    push(W1); push(WB);
    #1;
    chk("t5_load_rden", IN_W'(o_rden), IN_W'(1'b1));
    tick(); tick(); tick();
    beat("t5_b2", 32'h33333333, 1'b0, 1'b0);
    i_flush = 1'b1;
    #1;
    chk("t5_flush_rden", IN_W'(o_rden), IN_W'(1'b0));
    tick();
    i_flush = 1'b0;
    #1;
    idle("t5_post");
    chk("t5_post_rden", IN_W'(o_rden), IN_W'(1'b1));
    tick(); beat("t5_nb0", 32'hB0B0B0B0, 1'b0, 1'b0);
    tick(); tick(); tick();
    beat("t5_nb3", 32'hB3B3B3B3, 1'b1, 1'b0);
    tick(); idle("t5_after");

    // 6: asynchronous reset during beat 1
    push(W1);
    #1;
    chk("t6_load_rden", IN_W'(o_rden), IN_W'(1'b1));
    tick(); tick();
    beat("t6_b1", 32'h22222222, 1'b0, 1'b0);
    push(WC);
    #2;
    rstn = 1'b0;
    #1;
    idle("t6_rst");
    chk("t6_rst_rden", IN_W'(o_rden), IN_W'(1'b0));
    chk("t6_rst_data", IN_W'(o_data), '0);
    tick();
    rstn = 1'b1;
    #1;
    chk("t6_rel_rden", IN_W'(o_rden), IN_W'(1'b1));
    tick(); beat("t6_nb0", 32'hC0C0C0C0, 1'b0, 1'b0);
    tick(); beat("t6_nb1", 32'hC1C1C1C1, 1'b0, 1'b0);
    tick(); tick();
    beat("t6_nb3", 32'hC3C3C3C3, 1'b1, 1'b0);
    tick(); idle("t6_after");
    chk("t6_fifo_drained", IN_W'(i_empty), IN_W'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
